key_debounce_pulse: RTL and testbench

//  Front end for the push-buttons that drive the time-set and mode keys of the clock block.

---
 rtl/key_debounce_pulse.sv | 133 +++++++++++++
 tb/tb_key_debounce_pulse.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Push-button front end: per-key 2-FF synchroniser, debounce FSM and single-cycle press pulse.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce_pulse #(
    parameter int unsigned KEY_W        = 4,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned HOLD_CYC     = 50_000_000,
    parameter int unsigned REPEAT_CYC   = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_pulse,
    output logic [KEY_W-1:0] key_level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(HOLD_CYC) + 1;
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(HOLD_CYC);
    // After a repeat pulse the counter restarts so the next pulse lands REPEAT_CYC later.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(HOLD_CYC - REPEAT_CYC + 1);
`endif

    // The repeat reload only works when one period fits inside the initial hold time.
    if (REPEAT_CYC == 0 || REPEAT_CYC > HOLD_CYC + 1) begin : g_bad_repeat_cfg
        $error("key_debounce_pulse: REPEAT_CYC must be in 1..HOLD_CYC+1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb
    } key_state_t;

    logic [KEY_W-1:0] r_sync1;
    logic [KEY_W-1:0] r_sync2;
    logic [KEY_W-1:0] r_p;

    // Synchronisers reset to released; r_p is the inverted, registered pressed flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_p     <= '0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
            r_p     <= ~r_sync2;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_state_t       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_pulse;
        logic             r_level;
        logic             w_p;
`ifdef KEY_REPEAT_EN
        logic [RPT_W-1:0] r_rcnt;
`endif

        assign w_p = r_p[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= StIdle;
                r_cnt   <= '0;
                r_pulse <= 1'b0;
                r_level <= 1'b0;
`ifdef KEY_REPEAT_EN
                r_rcnt  <= '0;
`endif
            end else begin
                r_pulse <= 1'b0;
                unique case (r_state)
                    StIdle: begin
`ifdef KEY_REPEAT_EN
                        r_rcnt <= '0;
`endif
                        if (w_p) begin
                            r_state <= StPressDb;
                            r_cnt   <= '0;
                        end
                    end
                    StPressDb: begin
                        if (!w_p) begin
                            r_state <= StIdle;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= StHeld;
                            r_pulse <= 1'b1;
                            r_level <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    StHeld: begin
                        if (!w_p) begin
                            r_state <= StReleaseDb;
                            r_cnt   <= '0;
                        end
`ifdef KEY_REPEAT_EN
                        else if (r_rcnt == RPT_FIRST) begin
                            r_pulse <= 1'b1;
                            r_rcnt  <= RPT_RELOAD;
                        end else begin
                            r_rcnt <= r_rcnt + RPT_W'(1);
                        end
`endif
                    end
                    StReleaseDb: begin
                        // Repeat counter is left untouched here so a bounce resumes it.
                        if (w_p) begin
                            r_state <= StHeld;
                        end else if (r_cnt == CNT_LAST) begin
                            r_state <= StIdle;
                            r_level <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end

        assign key_pulse[g] = r_pulse;
        assign key_level[g] = r_level;
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse: directed scenarios plus randomised key activity,
// all compared every cycle against a run-length debounce model (repeat checks if KEY_REPEAT_EN).
module tb_key_debounce_pulse;

    localparam int KW   = 4;
    localparam int DEB  = 8;
    localparam int HOLD = 32;
    localparam int RPT  = 16;

    logic          clk;
    logic          rst_n;
    logic [KW-1:0] key_in;
    logic [KW-1:0] key_pulse;
    logic [KW-1:0] key_level;

    key_debounce_pulse #(
        .KEY_W       (KW),
        .DEBOUNCE_CYC(DEB),
        .HOLD_CYC    (HOLD),
        .REPEAT_CYC  (RPT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_pulse(key_pulse),
        .key_level(key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: a key's accepted level flips once the pressed flag (raw input seen three edges
    // late) has disagreed with it on DEB+1 consecutive edges. Repeats count edges spent
    // steadily pressed after acceptance.
    typedef struct packed {
        logic        level;
        logic        pulse;
        logic [7:0]  run;
        logic [15:0] rep;
    } kst_t;

    kst_t          m_st[KW];
    logic [2:0]    m_hist[KW];
    logic [KW-1:0] m_pulse;
    logic [KW-1:0] m_level;

    function automatic kst_t step(input kst_t s, input logic p_seen);
        kst_t n;
        n = s;
        n.pulse = 1'b0;
        if (p_seen != s.level) begin
            n.run = s.run + 8'd1;
            if (n.run == 8'(DEB + 1)) begin
                n.level = p_seen;
                n.run   = 8'd0;
                n.rep   = 16'd0;
                if (p_seen) n.pulse = 1'b1;
            end
        end else begin
            if (s.level && s.run == 8'd0) begin
                n.rep = s.rep + 16'd1;
`ifdef KEY_REPEAT_EN
                if (int'(n.rep) >= HOLD + 1 && (int'(n.rep) - (HOLD + 1)) % RPT == 0)
                    n.pulse = 1'b1;
`endif
            end
            n.run = 8'd0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KW; k++) begin
                m_st[k]   <= '0;
                m_hist[k] <= 3'b111;
            end
        end else begin
            for (int k = 0; k < KW; k++) begin
                m_st[k]   <= step(m_st[k], ~m_hist[k][2]);
                m_hist[k] <= {m_hist[k][1:0], key_in[k]};
            end
        end
    end

    always_comb begin
        m_pulse = '0;
        m_level = '0;
        for (int k = 0; k < KW; k++) begin
            m_pulse[k] = m_st[k].pulse;
            m_level[k] = m_st[k].level;
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_assert++;
                if (key_pulse !== m_pulse || key_level !== m_level) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t: pulse=%b level=%b, required pulse=%b level=%b",
                             $time, key_pulse, key_level, m_pulse, m_level);
                end
            end
        end
    end

    logic [KW-1:0] log_pulse[256];
    logic [KW-1:0] log_level[256];

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Logs outputs after edges base..base+n-1; returns with inputs safe to change.
    task automatic run_log(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            log_pulse[base + i] = key_pulse;
            log_level[base + i] = key_level;
            #1;
        end
    endtask

    function automatic int pulse_count(input int lo, input int hi);
        int c;
        c = 0;
        for (int i = lo; i <= hi; i++) if (log_pulse[i] != '0) c++;
        return c;
    endfunction

    function automatic int level_or(input int lo, input int hi);
        logic [KW-1:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v |= log_level[i];
        return int'(v);
    endfunction

    int seg[KW];
    int exp_edges[$];

    initial begin
        rst_n  = 1'b0;
        key_in = '1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        run_log(20, 0);
        check("t1_pulse_idle", pulse_count(0, 19), 0);
        check("t1_level_idle", level_or(0, 19), 0);

        // 2: single press on key 2
        key_in[2] = 1'b0;
        run_log(20, 0);
        check("t2_pulse_at_11", int'(log_pulse[11]), 4'b0100);
        check("t2_pulse_count", pulse_count(0, 19), 1);
        check("t2_level_before", int'(log_level[10]), 0);
        check("t2_level_after", int'(log_level[19]), 4'b0100);
        key_in[2] = 1'b1;
        run_log(15, 0);
        check("t2_level_released", int'(log_level[14]), 0);

        // 3: bouncing key 0 never accepted
        for (int r = 0; r < 4; r++) begin
            key_in[0] = 1'b0;
            run_log(5, r * 8);
            key_in[0] = 1'b1;
            run_log(3, r * 8 + 5);
        end
        run_log(12, 32);
        check("t3_bounce_pulse", pulse_count(0, 43), 0);
        check("t3_bounce_level", level_or(0, 43), 0);

        // 4: simultaneous press of keys 3 and 1, then release
        key_in[3] = 1'b0;
        key_in[1] = 1'b0;
        run_log(20, 0);
        check("t4_pulse_at_11", int'(log_pulse[11]), 4'b1010);
        check("t4_pulse_count", pulse_count(0, 19), 1);
        key_in[3] = 1'b1;
        key_in[1] = 1'b1;
        run_log(20, 0);
        check("t4_level_at_10", int'(log_level[10]), 4'b1010);
        check("t4_level_at_11", int'(log_level[11]), 0);

        // 5: reset mid press-debounce, key still held afterwards
        key_in[0] = 1'b0;
        run_log(8, 0);
        rst_n = 1'b0;
        run_log(3, 8);
        check("t5_no_pulse_in_reset", pulse_count(0, 10), 0);
        rst_n = 1'b1;
        run_log(20, 0);
        check("t5_pulse_at_11", int'(log_pulse[11]), 4'b0001);
        check("t5_pulse_count", pulse_count(0, 19), 1);
        key_in[0] = 1'b1;
        run_log(15, 0);

        // 6: long hold on key 1
`ifdef KEY_REPEAT_EN
        exp_edges = '{11, 44, 60, 76, 92};
`else
        exp_edges = '{11};
`endif
        key_in[1] = 1'b0;
        run_log(100, 0);
        foreach (exp_edges[i])
            check($sformatf("t6_pulse_at_%0d", exp_edges[i]), int'(log_pulse[exp_edges[i]]),
                  4'b0010);
        check("t6_pulse_count", pulse_count(0, 99), exp_edges.size());
        key_in[1] = 1'b1;
        run_log(15, 0);

        // Random phase: mix of bounces and long holds, occasional reset.
        for (int k = 0; k < KW; k++) seg[k] = $urandom_range(1, 40);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            for (int k = 0; k < KW; k++) begin
                seg[k]--;
                if (seg[k] <= 0) begin
                    key_in[k] = ~key_in[k];
                    seg[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8)
                                                         : $urandom_range(9, 90);
                end
            end
        end
        rst_n  = 1'b1;
        key_in = '1;
        repeat (20) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
